// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch sequencing controller:
// state encodings, the default exception vector and the bubble instruction.
package fetch_pkg;

   typedef logic [2:0] fetch_state_t;

   localparam fetch_state_t BOOT     = 3'd0;
   localparam fetch_state_t RUN      = 3'd1;
   localparam fetch_state_t STALL    = 3'd2;
   localparam fetch_state_t REDIRECT = 3'd3;
   localparam fetch_state_t FLUSH    = 3'd4;

   localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'h4000_0040;
   localparam logic [31:0] NOP_INST           = 32'h0000_0000;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping; used for the
// fetch performance counters.
module sat_counter #(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   logic [CNT_W-1:0] count_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_reg <= '0;
      end else if (inc && (count_reg != {CNT_W{1'b1}})) begin
         count_reg <= count_reg + 1'b1;
      end
   end

   assign count = count_reg;

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencer: arbitrates exception/branch/stall requests and
// drives the PC/IF hold and fetch-mux select controls, with flush bubbles.
module fetch_ctrl
   import fetch_pkg::*;
#(
   parameter int unsigned BOOT_CYCLES  = 2,
   parameter int unsigned FLUSH_CYCLES = 1,
   parameter logic [31:0] EXC_VECTOR   = EXC_VECTOR_DEFAULT,
   parameter int unsigned CNT_W        = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             stall_req,
   input  logic             br_req,
   input  logic [31:0]      br_target,
   input  logic             exc_req,
   input  logic [31:0]      exc_pc,
   output logic             hold_pc,
   output logic             hold_if,
   output logic             br,
   output logic             except,
   output logic [31:0]      pc_branch,
   output logic             flush_id,
   output logic [31:0]      epc,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] redir_cnt
);

   localparam logic [3:0] BOOT_LOAD  = 4'(BOOT_CYCLES - 1);
   localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

   fetch_state_t state_reg, state_next;
   logic [3:0]   cnt_reg, cnt_next;
   logic         kind_reg, kind_next;
   logic [31:0]  pc_branch_reg, pc_branch_next;
   logic [31:0]  epc_reg, epc_next;
   logic         take_redirect;

   always_comb begin
      state_next     = state_reg;
      cnt_next       = cnt_reg;
      kind_next      = kind_reg;
      pc_branch_next = pc_branch_reg;
      epc_next       = epc_reg;
      take_redirect  = 1'b0;

      case (state_reg)
         BOOT: begin
            if (cnt_reg == 4'd0) state_next = RUN;
            else                 cnt_next   = cnt_reg - 4'd1;
         end
         RUN, STALL: begin
            if (exc_req) begin
               pc_branch_next = EXC_VECTOR;
               epc_next       = exc_pc;
               kind_next      = 1'b1;
               state_next     = REDIRECT;
               take_redirect  = 1'b1;
            end else if (br_req) begin
               pc_branch_next = br_target;
               kind_next      = 1'b0;
               state_next     = REDIRECT;
               take_redirect  = 1'b1;
            end else if (stall_req) begin
               state_next = STALL;
            end else begin
               state_next = RUN;
            end
         end
         REDIRECT: begin
            state_next = FLUSH;
            cnt_next   = FLUSH_LOAD;
         end
         FLUSH: begin
            // Only exceptions are honoured here; branches/stalls are wrong-path.
            if (exc_req) begin
               pc_branch_next = EXC_VECTOR;
               epc_next       = exc_pc;
               kind_next      = 1'b1;
               state_next     = REDIRECT;
               take_redirect  = 1'b1;
            end else if (cnt_reg == 4'd0) begin
               state_next = RUN;
            end else begin
               cnt_next = cnt_reg - 4'd1;
            end
         end
         default: begin
            state_next = BOOT;
            cnt_next   = BOOT_LOAD;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= BOOT;
         cnt_reg       <= BOOT_LOAD;
         kind_reg      <= 1'b0;
         pc_branch_reg <= NOP_INST;
         epc_reg       <= '0;
      end else begin
         state_reg     <= state_next;
         cnt_reg       <= cnt_next;
         kind_reg      <= kind_next;
         pc_branch_reg <= pc_branch_next;
         epc_reg       <= epc_next;
      end
   end

   always_comb begin
      hold_pc  = 1'b0;
      hold_if  = 1'b0;
      flush_id = 1'b0;
      br       = 1'b0;
      except   = 1'b0;
      case (state_reg)
         BOOT: begin
            hold_pc  = 1'b1;
            hold_if  = 1'b1;
            flush_id = 1'b1;
         end
         STALL: begin
            hold_pc = 1'b1;
            hold_if = 1'b1;
         end
         REDIRECT: begin
            hold_if  = 1'b1;
            flush_id = 1'b1;
            br       = ~kind_reg;
            except   = kind_reg;
         end
         FLUSH: begin
            flush_id = 1'b1;
         end
         default: begin
            hold_pc = 1'b0;
         end
      endcase
   end

   assign pc_branch = pc_branch_reg;
   assign epc       = epc_reg;

   sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (state_reg == STALL),
      .count (stall_cnt)
   );

   sat_counter #(.CNT_W(CNT_W)) u_redir_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (take_redirect),
      .count (redir_cnt)
   );

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: directed per-cycle vectors push expected
// outputs; a negedge monitor pops and compares against the selected instance.
module tb_fetch_ctrl;

   // control word order: {hold_pc, hold_if, flush_id, br, except}
   localparam logic [4:0] E_BOOT  = 5'b11100;
   localparam logic [4:0] E_RUN   = 5'b00000;
   localparam logic [4:0] E_STALL = 5'b11000;
   localparam logic [4:0] E_BR    = 5'b01110;
   localparam logic [4:0] E_EXC   = 5'b01101;
   localparam logic [4:0] E_FLUSH = 5'b00100;
   localparam logic [31:0] VEC    = 32'h4000_0040;

   typedef struct {
      int          dut;
      string       tag;
      logic [4:0]  ctl;
      logic [31:0] pcb;
      logic [31:0] epc;
      logic [15:0] scnt;
      logic [15:0] rcnt;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic stall_req = 1'b0;
   logic br_req = 1'b0;
   logic exc_req = 1'b0;
   logic [31:0] br_target = '0;
   logic [31:0] exc_pc = '0;

   logic a_hold_pc, a_hold_if, a_br, a_except, a_flush_id;
   logic [31:0] a_pc_branch, a_epc;
   logic [15:0] a_stall_cnt, a_redir_cnt;
   logic b_hold_pc, b_hold_if, b_br, b_except, b_flush_id;
   logic [31:0] b_pc_branch, b_epc;
   logic [3:0] b_stall_cnt, b_redir_cnt;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   cur_dut = 0;
   logic [31:0] e_pcb = '0;
   logic [31:0] e_epc = '0;
   logic [15:0] e_scnt = '0;
   logic [15:0] e_rcnt = '0;

   always #5 clk = ~clk;

   fetch_ctrl dut_a (
      .clk(clk), .rst_n(rst_n), .stall_req(stall_req), .br_req(br_req),
      .br_target(br_target), .exc_req(exc_req), .exc_pc(exc_pc),
      .hold_pc(a_hold_pc), .hold_if(a_hold_if), .br(a_br), .except(a_except),
      .pc_branch(a_pc_branch), .flush_id(a_flush_id), .epc(a_epc),
      .stall_cnt(a_stall_cnt), .redir_cnt(a_redir_cnt)
   );

   fetch_ctrl #(.BOOT_CYCLES(2), .FLUSH_CYCLES(3), .CNT_W(4)) dut_b (
      .clk(clk), .rst_n(rst_n), .stall_req(stall_req), .br_req(br_req),
      .br_target(br_target), .exc_req(exc_req), .exc_pc(exc_pc),
      .hold_pc(b_hold_pc), .hold_if(b_hold_if), .br(b_br), .except(b_except),
      .pc_branch(b_pc_branch), .flush_id(b_flush_id), .epc(b_epc),
      .stall_cnt(b_stall_cnt), .redir_cnt(b_redir_cnt)
   );

   // One call = one clock cycle: inputs sampled at its closing edge, and the
   // outputs expected during the cycle.
   task automatic cyc(input string tag, input logic [4:0] ctl,
                      input logic s, input logic b, input logic x);
      exp_t t;
      stall_req = s;
      br_req    = b;
      exc_req   = x;
      t.dut  = cur_dut;
      t.tag  = tag;
      t.ctl  = ctl;
      t.pcb  = e_pcb;
      t.epc  = e_epc;
      t.scnt = e_scnt;
      t.rcnt = e_rcnt;
      sb.push_back(t);
      @(posedge clk);
      #1;
   endtask

   task automatic clear_exp();
      e_pcb  = '0;
      e_epc  = '0;
      e_scnt = '0;
      e_rcnt = '0;
   endtask

   always @(negedge clk) begin : monitor
      exp_t        t;
      logic [4:0]  g_ctl;
      logic [31:0] g_pcb, g_epc;
      logic [15:0] g_scnt, g_rcnt;
      if (sb.size() > 0) begin
         t = sb.pop_front();
         if (t.dut == 0) begin
            g_ctl  = {a_hold_pc, a_hold_if, a_flush_id, a_br, a_except};
            g_pcb  = a_pc_branch;
            g_epc  = a_epc;
            g_scnt = a_stall_cnt;
            g_rcnt = a_redir_cnt;
         end else begin
            g_ctl  = {b_hold_pc, b_hold_if, b_flush_id, b_br, b_except};
            g_pcb  = b_pc_branch;
            g_epc  = b_epc;
            g_scnt = {12'b0, b_stall_cnt};
            g_rcnt = {12'b0, b_redir_cnt};
         end
         checks++;
         if (g_ctl !== t.ctl || g_pcb !== t.pcb || g_epc !== t.epc ||
             g_scnt !== t.scnt || g_rcnt !== t.rcnt) begin
            errors++;
            $display("FAIL %s: got ctl=%b pc_branch=%h epc=%h stall_cnt=%0d redir_cnt=%0d, want ctl=%b pc_branch=%h epc=%h stall_cnt=%0d redir_cnt=%0d",
                     t.tag, g_ctl, g_pcb, g_epc, g_scnt, g_rcnt,
                     t.ctl, t.pcb, t.epc, t.scnt, t.rcnt);
         end else begin
            $display("ok   %s: ctl=%b pc_branch=%h epc=%h stall_cnt=%0d redir_cnt=%0d",
                     t.tag, g_ctl, g_pcb, g_epc, g_scnt, g_rcnt);
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
      $fatal(1, "watchdog expired");
   end

   initial begin : stimulus
      @(posedge clk);
      #1;

      // ---------------- instance A: default parameters ----------------
      cur_dut = 0;
      clear_exp();
      cyc("a_reset", E_BOOT, 0, 0, 0);
      rst_n = 1'b1;
      cyc("a_boot1", E_BOOT, 0, 1, 0);
      cyc("a_boot2", E_BOOT, 0, 1, 0);
      cyc("a_run_after_boot", E_RUN, 0, 0, 0);
      cyc("a_run_idle", E_RUN, 0, 0, 0);

      br_target = 32'h0000_0020;
      cyc("a_br_req", E_RUN, 0, 1, 0);
      e_pcb = 32'h0000_0020; e_rcnt = 16'd1;
      cyc("a_br_redirect", E_BR, 0, 0, 0);
      cyc("a_br_flush", E_FLUSH, 0, 0, 0);
      cyc("a_br_run", E_RUN, 0, 0, 0);

      br_target = 32'h0000_0100;
      exc_pc    = 32'h0000_0014;
      cyc("a_excbr_req", E_RUN, 0, 1, 1);
      e_pcb = VEC; e_epc = 32'h0000_0014; e_rcnt = 16'd2;
      cyc("a_exc_redirect", E_EXC, 0, 0, 0);
      cyc("a_exc_flush", E_FLUSH, 0, 0, 0);
      cyc("a_exc_run", E_RUN, 0, 0, 0);

      cyc("a_stall_req", E_RUN, 1, 0, 0);
      for (int i = 1; i <= 5; i++) begin
         e_scnt = 16'(i - 1);
         cyc($sformatf("a_stall%0d", i), E_STALL, (i < 5) ? 1'b1 : 1'b0, 0, 0);
      end
      e_scnt = 16'd5;
      cyc("a_stall_done", E_RUN, 0, 0, 0);

      // ------------- instance B: FLUSH_CYCLES=3, CNT_W=4 --------------
      cur_dut = 1;
      rst_n = 1'b0;
      clear_exp();
      cyc("b_reset", E_BOOT, 0, 0, 0);
      rst_n = 1'b1;
      cyc("b_boot1", E_BOOT, 0, 0, 0);
      cyc("b_boot2", E_BOOT, 0, 0, 0);

      br_target = 32'h0000_0040;
      cyc("b_br_req", E_RUN, 0, 1, 0);
      e_pcb = 32'h0000_0040; e_rcnt = 16'd1;
      cyc("b_br_redirect", E_BR, 0, 0, 0);
      br_target = 32'h0000_0080;
      cyc("b_flush1_wrongpath", E_FLUSH, 1, 1, 0);
      exc_pc = 32'h0000_001c;
      cyc("b_flush2_exc", E_FLUSH, 0, 0, 1);
      e_pcb = VEC; e_epc = 32'h0000_001c; e_rcnt = 16'd2;
      cyc("b_exc_redirect", E_EXC, 0, 0, 0);
      cyc("b_flush_a", E_FLUSH, 0, 0, 0);
      cyc("b_flush_b_br", E_FLUSH, 0, 1, 0);
      cyc("b_flush_c", E_FLUSH, 0, 0, 0);
      cyc("b_run", E_RUN, 0, 0, 0);

      br_target = 32'h0000_0060;
      cyc("b_br2_req", E_RUN, 0, 1, 0);
      // reset lands mid-REDIRECT, well before the next clock edge
      rst_n = 1'b0;
      clear_exp();
      cyc("b_async_rst", E_BOOT, 0, 0, 0);
      rst_n = 1'b1;
      cyc("b_reboot1", E_BOOT, 0, 0, 0);
      cyc("b_reboot2", E_BOOT, 0, 0, 0);
      cyc("b_run_no_partial", E_RUN, 0, 0, 0);

      cyc("b_sat_req", E_RUN, 1, 0, 0);
      for (int i = 1; i <= 20; i++) begin
         e_scnt = (i - 1 > 15) ? 16'd15 : 16'(i - 1);
         cyc($sformatf("b_sat%0d", i), E_STALL, (i < 20) ? 1'b1 : 1'b0, 0, 0);
      end
      e_scnt = 16'd15;
      cyc("b_sat_done", E_RUN, 0, 0, 0);

      @(negedge clk);
      #1;
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d pending entries, want 0", sb.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
